// File: rtl/core_pkg.sv
// Shared core definitions: memory op encodings and store-path types.
// Optional feature macro used by the store path: MEM_STORE_SPLIT_EN.
package core;

    // Memory op code: MSB set marks a store, lower bits select the width.
    localparam int MEM_OP_BITS = 4;
    localparam logic STORE_PRFX = 1'b1;

    typedef logic [MEM_OP_BITS-1:0] mem_op_t;

    localparam mem_op_t MEM_NOP = 4'b0000;
    localparam mem_op_t LB      = 4'b0001;
    localparam mem_op_t LH      = 4'b0010;
    localparam mem_op_t LW      = 4'b0011;
    localparam mem_op_t LBU     = 4'b0100;
    localparam mem_op_t LHU     = 4'b0101;
    localparam mem_op_t SB      = 4'b1000;
    localparam mem_op_t SH      = 4'b1001;
    localparam mem_op_t SW      = 4'b1010;

    // Data memory byte-enable width (one bit per byte lane of a 32-bit word).
    localparam int DMEM_BE_W = 4;

    // Store sequencer states.
    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        BEAT_LO = 2'd1,
        BEAT_HI = 2'd2
    } st_state_t;

    // True for any op the store path should act on.
    function automatic logic is_store(input mem_op_t op);
        return (op != MEM_NOP) && (op[MEM_OP_BITS-1] == STORE_PRFX);
    endfunction

endpackage

// File: rtl/mem_store_align_lane_gen.sv
// Combinational store lane generator: turns (op, byte offset, rs2 data)
// into byte enables and lane-shifted data for the low word and for the
// spill-over into the next word, plus a word-crossing (misaligned) flag.
module store_lane_gen
    import core::*;
(
    input  mem_op_t                op_i,
    input  logic [1:0]             off_i,
    input  logic [31:0]            wdata_i,
    output logic [DMEM_BE_W-1:0]   be_lo_o,
    output logic [31:0]            data_lo_o,
    output logic [DMEM_BE_W-1:0]   be_hi_o,
    output logic [31:0]            data_hi_o,
    output logic                   misaligned_o
);

    logic [DMEM_BE_W-1:0]   mask;
    logic [31:0]            src;
    logic [2*DMEM_BE_W-1:0] be_wide;
    logic [63:0]            data_wide;

    // Select the width mask and the zero-extended source, then shift both
    // across a two-word window so the spill-over lands in the upper word.
    always_comb begin
        mask = '0;
        src  = '0;
        case (op_i)
            SB: begin
                mask = 4'b0001;
                src  = {24'b0, wdata_i[7:0]};
            end
            SH: begin
                mask = 4'b0011;
                src  = {16'b0, wdata_i[15:0]};
            end
            SW: begin
                mask = 4'b1111;
                src  = wdata_i;
            end
            default: begin
                mask = '0;
                src  = '0;
            end
        endcase
        be_wide      = {4'b0000, mask} << off_i;
        data_wide    = {32'b0, src} << {off_i, 3'b000};
        misaligned_o = ((op_i == SH) && (off_i == 2'd3)) ||
                       ((op_i == SW) && (off_i != 2'd0));
    end

    assign be_lo_o = be_wide[DMEM_BE_W-1:0];
    assign be_hi_o = be_wide[2*DMEM_BE_W-1:DMEM_BE_W];

    // Disabled lanes are forced to zero so the bus never carries stale bytes.
    generate
        for (genvar gi = 0; gi < DMEM_BE_W; gi++) begin : g_lane
            assign data_lo_o[8*gi +: 8] = be_lo_o[gi] ? data_wide[8*gi +: 8]      : 8'h00;
            assign data_hi_o[8*gi +: 8] = be_hi_o[gi] ? data_wide[32 + 8*gi +: 8] : 8'h00;
        end
    endgenerate

endmodule

// File: rtl/mem_store_align.sv
// MEM-stage store aligner: accepts SB/SH/SW, drives a req/gnt data-memory
// beat with byte strobes and lane-aligned data, and stalls the pipeline
// until the store is granted. A grant timeout raises bus_err_o.
// Macro MEM_STORE_SPLIT_EN: when defined, word-crossing stores are issued
// as two beats; otherwise they are rejected with misaligned_o.
module mem_store_align
    import core::*;
#(
    parameter int GNT_TIMEOUT = 16
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  req_valid_i,
    input  logic [MEM_OP_BITS-1:0] mem_op_i,
    input  logic [31:0]           addr_i,
    input  logic [31:0]           wdata_i,
    output logic                  stall_o,
    output logic                  dmem_req_o,
    output logic [31:0]           dmem_addr_o,
    output logic [31:0]           dmem_wdata_o,
    output logic [DMEM_BE_W-1:0]  dmem_be_o,
    input  logic                  dmem_gnt_i,
    output logic                  done_o,
    output logic                  misaligned_o,
    output logic                  bus_err_o
);

    localparam int TMO_W = (GNT_TIMEOUT > 0) ? $clog2(GNT_TIMEOUT + 1) : 1;
    localparam logic [TMO_W-1:0] TMO_LIMIT = TMO_W'(GNT_TIMEOUT);
    localparam bit TMO_EN = (GNT_TIMEOUT != 0);

    st_state_t         state_q, state_d;
    mem_op_t           op_q, op_d;
    logic [1:0]        off_q, off_d;
    logic [31:0]       addr_q, addr_d;
    logic [31:0]       wdata_q, wdata_d;
    logic [TMO_W-1:0]  tmo_q, tmo_d;

    logic [DMEM_BE_W-1:0] be_lo, be_hi;
    logic [31:0]          data_lo, data_hi;
    logic                 lane_mis;
    logic                 accept;
    logic                 timed_out;
    logic                 split_beat;
    logic                 reject_mis;

    store_lane_gen u_lane_gen (
        .op_i         (op_q),
        .off_i        (off_q),
        .wdata_i      (wdata_q),
        .be_lo_o      (be_lo),
        .data_lo_o    (data_lo),
        .be_hi_o      (be_hi),
        .data_hi_o    (data_hi),
        .misaligned_o (lane_mis)
    );

`ifdef MEM_STORE_SPLIT_EN
    assign split_beat = lane_mis;
    assign reject_mis = 1'b0;
`else
    assign split_beat = 1'b0;
    assign reject_mis = lane_mis;
`endif

    assign accept    = (state_q == IDLE) && req_valid_i && is_store(mem_op_i);
    assign timed_out = TMO_EN && (tmo_q == TMO_LIMIT);

    // Next-state, capture and bus/handshake outputs for the store sequencer.
    always_comb begin
        state_d      = state_q;
        op_d         = op_q;
        off_d        = off_q;
        addr_d       = addr_q;
        wdata_d      = wdata_q;
        tmo_d        = tmo_q;
        stall_o      = 1'b0;
        dmem_req_o   = 1'b0;
        dmem_addr_o  = '0;
        dmem_wdata_o = '0;
        dmem_be_o    = '0;
        done_o       = 1'b0;
        misaligned_o = 1'b0;
        bus_err_o    = 1'b0;

        case (state_q)
            IDLE: begin
                if (accept) begin
                    stall_o = 1'b1;
                    op_d    = mem_op_i;
                    off_d   = addr_i[1:0];
                    addr_d  = {addr_i[31:2], 2'b00};
                    wdata_d = wdata_i;
                    tmo_d   = '0;
                    state_d = BEAT_LO;
                end
            end

            BEAT_LO: begin
                if (reject_mis) begin
                    // Word-crossing store without split support: no beat.
                    misaligned_o = 1'b1;
                    state_d      = IDLE;
                end else if (timed_out) begin
                    bus_err_o = 1'b1;
                    tmo_d     = '0;
                    state_d   = IDLE;
                end else begin
                    dmem_req_o   = 1'b1;
                    dmem_addr_o  = addr_q;
                    dmem_be_o    = be_lo;
                    dmem_wdata_o = data_lo;
                    stall_o      = 1'b1;
                    if (dmem_gnt_i) begin
                        tmo_d = '0;
                        if (split_beat) begin
                            state_d = BEAT_HI;
                        end else begin
                            done_o  = 1'b1;
                            stall_o = 1'b0;
                            state_d = IDLE;
                        end
                    end else if (TMO_EN) begin
                        tmo_d = tmo_q + TMO_W'(1);
                    end
                end
            end

            BEAT_HI: begin
                if (timed_out) begin
                    bus_err_o = 1'b1;
                    tmo_d     = '0;
                    state_d   = IDLE;
                end else begin
                    dmem_req_o   = 1'b1;
                    dmem_addr_o  = addr_q + 32'd4;
                    dmem_be_o    = be_hi;
                    dmem_wdata_o = data_hi;
                    stall_o      = 1'b1;
                    if (dmem_gnt_i) begin
                        tmo_d   = '0;
                        done_o  = 1'b1;
                        stall_o = 1'b0;
                        state_d = IDLE;
                    end else if (TMO_EN) begin
                        tmo_d = tmo_q + TMO_W'(1);
                    end
                end
            end

            default: begin
                tmo_d   = '0;
                state_d = IDLE;
            end
        endcase
    end

    // State and captured-store registers; reset discards any pending beat.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= IDLE;
            op_q    <= MEM_NOP;
            off_q   <= '0;
            addr_q  <= '0;
            wdata_q <= '0;
            tmo_q   <= '0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            off_q   <= off_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            tmo_q   <= tmo_d;
        end
    end

endmodule

// File: tb/tb_mem_store_align.sv
// Testbench for mem_store_align (GNT_TIMEOUT = 4). Expectations adapt to
// whether MEM_STORE_SPLIT_EN is defined for the build.
module tb_mem_store_align;
    import core::*;

    logic                 clk_i = 1'b0;
    logic                 rst_ni;
    logic                 req_valid_i;
    logic [MEM_OP_BITS-1:0] mem_op_i;
    logic [31:0]          addr_i;
    logic [31:0]          wdata_i;
    logic                 stall_o;
    logic                 dmem_req_o;
    logic [31:0]          dmem_addr_o;
    logic [31:0]          dmem_wdata_o;
    logic [DMEM_BE_W-1:0] dmem_be_o;
    logic                 dmem_gnt_i;
    logic                 done_o;
    logic                 misaligned_o;
    logic                 bus_err_o;

    int tests = 0;
    int fails = 0;

    always #5 clk_i = ~clk_i;

    mem_store_align #(.GNT_TIMEOUT(4)) dut (
        .clk_i        (clk_i),
        .rst_ni       (rst_ni),
        .req_valid_i  (req_valid_i),
        .mem_op_i     (mem_op_i),
        .addr_i       (addr_i),
        .wdata_i      (wdata_i),
        .stall_o      (stall_o),
        .dmem_req_o   (dmem_req_o),
        .dmem_addr_o  (dmem_addr_o),
        .dmem_wdata_o (dmem_wdata_o),
        .dmem_be_o    (dmem_be_o),
        .dmem_gnt_i   (dmem_gnt_i),
        .done_o       (done_o),
        .misaligned_o (misaligned_o),
        .bus_err_o    (bus_err_o)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Reference: place each stored byte at its own byte address and group the
    // bytes by the memory word they fall into.
    task automatic model(input mem_op_t op, input logic [31:0] addr, input logic [31:0] wdata,
                         output int nb, output logic reject,
                         output logic [31:0] ea0, output logic [31:0] ea1,
                         output logic [3:0] eb0, output logic [3:0] eb1,
                         output logic [31:0] ed0, output logic [31:0] ed1);
        int size;
        logic [31:0] byte_addr;
        logic [31:0] base;
        size = (op == SB) ? 1 : (op == SH) ? 2 : 4;
        base = addr & 32'hFFFF_FFFC;
        ea0 = base;
        ea1 = base + 32'd4;
        eb0 = '0; eb1 = '0; ed0 = '0; ed1 = '0;
        nb = 1;
        for (int i = 0; i < size; i++) begin
            byte_addr = addr + 32'(i);
            if ((byte_addr & 32'hFFFF_FFFC) == base) begin
                eb0[byte_addr[1:0]] = 1'b1;
                ed0[8*byte_addr[1:0] +: 8] = wdata[8*i +: 8];
            end else begin
                nb = 2;
                eb1[byte_addr[1:0]] = 1'b1;
                ed1[8*byte_addr[1:0] +: 8] = wdata[8*i +: 8];
            end
        end
`ifdef MEM_STORE_SPLIT_EN
        reject = 1'b0;
`else
        reject = (nb == 2);
`endif
    endtask

    // One store transaction with the given grant delays per beat.
    task automatic run_store(input string tag, input mem_op_t op, input logic [31:0] addr,
                             input logic [31:0] wdata, input int d0, input int d1);
        int nb;
        logic reject;
        logic [31:0] ea[2];
        logic [3:0]  eb[2];
        logic [31:0] ed[2];
        int dly;
        model(op, addr, wdata, nb, reject, ea[0], ea[1], eb[0], eb[1], ed[0], ed[1]);
        $display("[TB] %s op=%0h addr=%08h wdata=%08h beats=%0d reject=%0d d0=%0d d1=%0d",
                 tag, op, addr, wdata, nb, reject, d0, d1);

        @(negedge clk_i);
        req_valid_i = 1'b1; mem_op_i = op; addr_i = addr; wdata_i = wdata; dmem_gnt_i = 1'b0;
        #1;
        check($sformatf("%s acc_stall", tag), stall_o, 1);
        check($sformatf("%s acc_req", tag), dmem_req_o, 0);
        @(negedge clk_i);

        if (reject) begin
            req_valid_i = 1'($urandom_range(0, 1)); mem_op_i = SW;
            addr_i = $urandom; wdata_i = $urandom; dmem_gnt_i = 1'($urandom_range(0, 1));
            #1;
            check($sformatf("%s mis_pulse", tag), misaligned_o, 1);
            check($sformatf("%s mis_req", tag), dmem_req_o, 0);
            check($sformatf("%s mis_stall", tag), stall_o, 0);
            check($sformatf("%s mis_done", tag), done_o, 0);
            @(negedge clk_i);
        end else begin
            for (int b = 0; b < nb; b++) begin
                dly = (b == 0) ? d0 : d1;
                for (int k = 0; k <= dly; k++) begin
                    req_valid_i = 1'($urandom_range(0, 1)); mem_op_i = SW;
                    addr_i = $urandom; wdata_i = $urandom;
                    dmem_gnt_i = (k == dly);
                    #1;
                    check($sformatf("%s b%0d req", tag, b), dmem_req_o, 1);
                    check($sformatf("%s b%0d addr", tag, b), dmem_addr_o, ea[b]);
                    check($sformatf("%s b%0d be", tag, b), dmem_be_o, eb[b]);
                    check($sformatf("%s b%0d data", tag, b), dmem_wdata_o, ed[b]);
                    check($sformatf("%s b%0d done", tag, b), done_o,
                          ((k == dly) && (b == nb - 1)) ? 1 : 0);
                    check($sformatf("%s b%0d stall", tag, b), stall_o,
                          ((k == dly) && (b == nb - 1)) ? 0 : 1);
                    check($sformatf("%s b%0d mis", tag, b), misaligned_o, 0);
                    @(negedge clk_i);
                end
            end
        end

        req_valid_i = 1'b0; dmem_gnt_i = 1'b0; mem_op_i = MEM_NOP;
        #1;
        check($sformatf("%s post_req", tag), dmem_req_o, 0);
        check($sformatf("%s post_stall", tag), stall_o, 0);
        check($sformatf("%s post_done", tag), done_o, 0);
        check($sformatf("%s post_mis", tag), misaligned_o, 0);
        check($sformatf("%s post_berr", tag), bus_err_o, 0);
    endtask

    // A non-store op must neither stall nor touch the bus.
    task automatic run_nonstore(input string tag, input mem_op_t op);
        $display("[TB] %s non-store op=%0h", tag, op);
        @(negedge clk_i);
        req_valid_i = 1'b1; mem_op_i = op; addr_i = $urandom; wdata_i = $urandom; dmem_gnt_i = 1'b1;
        #1;
        check($sformatf("%s ns_stall", tag), stall_o, 0);
        check($sformatf("%s ns_req", tag), dmem_req_o, 0);
        @(negedge clk_i);
        req_valid_i = 1'b0; mem_op_i = MEM_NOP;
        #1;
        check($sformatf("%s ns_req2", tag), dmem_req_o, 0);
        check($sformatf("%s ns_done", tag), done_o, 0);
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        mem_op_t ops[3];
        mem_op_t rop;
        logic [31:0] raddr;
        ops[0] = SB; ops[1] = SH; ops[2] = SW;

        rst_ni = 1'b0; req_valid_i = 1'b0; mem_op_i = MEM_NOP;
        addr_i = '0; wdata_i = '0; dmem_gnt_i = 1'b0;
        repeat (2) @(negedge clk_i);
        #1;
        $display("[TB] reset state");
        check("rst stall", stall_o, 0);
        check("rst req", dmem_req_o, 0);
        check("rst addr", dmem_addr_o, 0);
        check("rst wdata", dmem_wdata_o, 0);
        check("rst be", dmem_be_o, 0);
        check("rst done", done_o, 0);
        check("rst mis", misaligned_o, 0);
        check("rst berr", bus_err_o, 0);
        @(negedge clk_i);
        rst_ni = 1'b1;

        // Directed cases.
        run_store("sb_imm",   SB, 32'h0000_1003, 32'hAABB_CCDD, 0, 0);
        run_store("sh_dly3",  SH, 32'h0000_2002, 32'h1234_5678, 3, 0);
        run_store("sw_off1",  SW, 32'h0000_3001, 32'h1122_3344, 0, 0);
        run_store("sw_wrap",  SW, 32'hFFFF_FFFE, 32'hCAFE_F00D, 1, 2);
        run_store("sh_off3",  SH, 32'h0000_0103, 32'hDEAD_BEEF, 2, 1);
        run_store("sh_off1",  SH, 32'h0000_0101, 32'h0000_A55A, 0, 0);
        run_store("sw_align", SW, 32'h8000_0000, 32'h0102_0304, 2, 0);
        run_nonstore("lw",  LW);
        run_nonstore("nop", MEM_NOP);
        run_nonstore("lbu", LBU);

        // Grant timeout: four ungranted request cycles, then bus error.
        $display("[TB] timeout sw addr=00004000");
        @(negedge clk_i);
        req_valid_i = 1'b1; mem_op_i = SW; addr_i = 32'h0000_4000; wdata_i = 32'h5555_AAAA;
        dmem_gnt_i = 1'b0;
        @(negedge clk_i);
        req_valid_i = 1'b0; mem_op_i = MEM_NOP;
        for (int k = 0; k < 4; k++) begin
            #1;
            check($sformatf("tmo c%0d req", k), dmem_req_o, 1);
            check($sformatf("tmo c%0d stall", k), stall_o, 1);
            check($sformatf("tmo c%0d berr", k), bus_err_o, 0);
            @(negedge clk_i);
        end
        #1;
        check("tmo berr", bus_err_o, 1);
        check("tmo req", dmem_req_o, 0);
        check("tmo stall", stall_o, 0);
        check("tmo done", done_o, 0);
        @(negedge clk_i);
        #1;
        check("tmo berr_clr", bus_err_o, 0);
        check("tmo idle_req", dmem_req_o, 0);

        // Reset during BEAT_LO: request drops at once, nothing left over.
        $display("[TB] reset during beat");
        @(negedge clk_i);
        req_valid_i = 1'b1; mem_op_i = SB; addr_i = 32'h0000_5001; wdata_i = 32'h0000_0077;
        @(negedge clk_i);
        req_valid_i = 1'b0; mem_op_i = MEM_NOP; dmem_gnt_i = 1'b0;
        #1;
        check("rstmid req_before", dmem_req_o, 1);
        #1;
        rst_ni = 1'b0;
        #1;
        check("rstmid req_async", dmem_req_o, 0);
        check("rstmid stall", stall_o, 0);
        @(negedge clk_i);
        rst_ni = 1'b1;
        dmem_gnt_i = 1'b1;
        #1;
        check("rstmid after_req", dmem_req_o, 0);
        check("rstmid after_done", done_o, 0);
        @(negedge clk_i);
        #1;
        check("rstmid after_req2", dmem_req_o, 0);
        dmem_gnt_i = 1'b0;

        // Randomized stores checked against the byte-placement model.
        for (int n = 0; n < 40; n++) begin
            rop   = ops[$urandom_range(0, 2)];
            raddr = $urandom;
            if (n % 8 == 7) raddr = 32'hFFFF_FFFC | 32'($urandom_range(0, 3));
            run_store($sformatf("rnd%0d", n), rop, raddr, $urandom,
                      $urandom_range(0, 3), $urandom_range(0, 3));
            if (n % 10 == 5) run_nonstore($sformatf("rnd_ns%0d", n), LH);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/mem_store_align.md
Name: mem_store_align

Overview:
- Store-side counterpart of the MEM-stage load sign-extension path.
- Takes a store op (SB/SH/SW) with address and rs2 data from the MEM stage.
- Produces byte strobes and lane-aligned write data for the data memory, and drives a req/gnt handshake.
- Holds the pipeline with a stall until the store is fully granted. Optionally splits misaligned stores into two word beats.

Parameters:
- GNT_TIMEOUT, 16: cycles to wait for dmem_gnt_i before flagging a bus error; 0 disables the timeout.

Ports:
- clk_i  in  1  core clock
- rst_ni  in  1  asynchronous active-low reset
- req_valid_i  in  1  MEM-stage instruction valid
- mem_op_i  in  core::MEM_OP_BITS  memory op code; only STORE_PRFX ops are acted on
- addr_i  in  32  effective byte address
- wdata_i  in  32  rs2 data
- stall_o  out  1  hold the MEM stage
- dmem_req_o  out  1  write request
- dmem_addr_o  out  32  word-aligned address ([1:0] = 0)
- dmem_wdata_o  out  32  lane-shifted data
- dmem_be_o  out  4  byte enables
- dmem_gnt_i  in  1  memory accepts the beat in the cycle req & gnt
- done_o  out  1  one-cycle pulse when the last beat is granted
- misaligned_o  out  1  one-cycle pulse; misaligned store rejected
- bus_err_o  out  1  one-cycle pulse; grant timeout

Behaviour:
- Reset values: all outputs 0; state IDLE; timeout counter 0.
- Reset asserted mid-operation: dmem_req_o drops asynchronously and the pending store is discarded.
- States: IDLE, BEAT_LO, BEAT_HI.
- Accept condition: in IDLE, req_valid_i && mem_op_i != MEM_NOP && mem_op_i[MSB] == STORE_PRFX.
  - On accept: register op, off = addr_i[1:0], word address = {addr_i[31:2], 2'b00}, and wdata_i.
  - Go to BEAT_LO. Non-store ops are ignored, with no stall.
- stall_o (combinational) = accept-condition-in-IDLE OR (state != IDLE AND NOT final-beat-granted-this-cycle).
  - On the final grant cycle stall_o is 0 so the pipeline advances.
  - req_valid_i seen while not in IDLE is ignored.
- Lane rules for the low beat:
  - SB: be = 4'b0001 << off; data = {24'b0, wdata[7:0]} << 8*off.
  - SH: be = 4'b0011 << off, truncated to 4 bits; data = {16'b0, wdata[15:0]} << 8*off, truncated.
  - SW: be = 4'b1111 << off, truncated; data = wdata << 8*off.
  - Disabled lanes always carry 0.
- Misaligned means SH with off == 3, or SW with off != 0.
- Beats:
  - BEAT_LO asserts dmem_req_o with the registered address, be and data.
  - Outputs stay stable until dmem_gnt_i; the beat completes on the cycle req && gnt.
  - If aligned: the grant pulses done_o and returns to IDLE.
- Minimum latency for an aligned store: accept cycle plus 1 cycle (gnt in the first BEAT_LO cycle). stall_o is high for exactly one cycle.
- Timeout: counter increments each BEAT cycle without gnt and clears on gnt.
  - When it reaches GNT_TIMEOUT: pulse bus_err_o, drop the request, return to IDLE, deassert stall.

Optional Feature:
- Macro: MEM_STORE_SPLIT_EN.
- Defined: a misaligned low beat grant moves to BEAT_HI.
  - BEAT_HI: addr = word address + 4, wrapping modulo 2^32.
  - SH: be = 4'b0001, data = {24'b0, wdata[15:8]}.
  - SW: be = 4'b1111 >> (4-off), data = wdata >> 8*(4-off).
  - The BEAT_HI grant pulses done_o and returns to IDLE.
- Undefined:
  - A misaligned accept issues no bus beat; misaligned_o pulses in the cycle after accept; state returns to IDLE.
  - stall_o is high for the accept cycle only.

Decomposition:
- Add to package core: typedef st_state_t {IDLE, BEAT_LO, BEAT_HI} and localparam DMEM_BE_W = 4.
- Reuse existing SB/SH/SW/STORE_PRFX/MEM_NOP/MEM_OP_BITS.
- One natural combinational sub-module, store_lane_gen: (op, off, wdata) -> (be_lo, data_lo, be_hi, data_hi, misaligned).

Test Plan:
- SB, addr 0x1003, wdata 0xAABBCCDD, gnt immediate -> dmem_addr 0x1000, be 4'b1000, wdata 0xDD000000, done_o pulse, stall_o high 1 cycle.
- SH, addr 0x2002, wdata 0x1234_5678, gnt delayed 3 cycles -> be 4'b1100, wdata 0x56780000 held stable 4 cycles, stall_o high 4 cycles.
- SW, addr 0x3001, wdata 0x11223344, with MEM_STORE_SPLIT_EN:
  - Expected: beat1 0x3000/be 1110/0x22334400, then beat2 0x3004/be 0001/0x00000011, single done_o.
  - Same stimulus without the macro: no dmem_req_o, misaligned_o pulse.
- LW/ALU op with req_valid_i -> no dmem_req_o, stall_o 0.
- GNT_TIMEOUT=4, gnt never asserted -> bus_err_o after 4 request cycles, req drops, stall_o releases.
- rst_ni low during BEAT_LO -> dmem_req_o 0 immediately; after release, state IDLE with no residual beat.
